// File: rtl/fft_frame_feeder.sv
// Strips the cyclic prefix from a gappy sample stream and collects NFFT-sample frames
// into a ping-pong buffer. Each frame is replayed to the FFT as one unbroken burst.
module fft_frame_feeder #(
    parameter int SIZE_BUFFER   = 8,
    parameter int DATA_FFT_SIZE = 16,
    parameter int CP_LEN        = 16,
    parameter int CNT_W         = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_in,
    input  logic                     frame_start,
    input  logic [DATA_FFT_SIZE-1:0] data_in_i,
    input  logic [DATA_FFT_SIZE-1:0] data_in_q,
    input  logic                     flag_wayt_data,
    output logic                     valid_out,
    output logic [DATA_FFT_SIZE-1:0] data_out_i,
    output logic [DATA_FFT_SIZE-1:0] data_out_q,
    output logic                     overflow,
    output logic                     resync,
    output logic [CNT_W-1:0]         frame_count,
    output logic                     busy
);
    localparam int AW = SIZE_BUFFER;
    localparam int DW = 2 * DATA_FFT_SIZE;
    localparam logic [AW-1:0] LAST_ADDR = '1;
    localparam logic [AW-1:0] CP_LAST   = AW'(CP_LEN - 1);

    typedef enum logic [1:0] {IN_IDLE, IN_SKIP, IN_FILL} in_state_t;
    typedef enum logic {OUT_IDLE, OUT_RUN} out_state_t;

    in_state_t  in_st, in_nxt;
    out_state_t out_st, out_nxt;
    logic [AW-1:0] skip_cnt, skip_nxt, wr_addr, wa_nxt, wr_ptr, rd_addr, ra_nxt;
    logic          wr_bank, rd_bank, pend, pend_bank;
    logic [1:0]    full;
    logic          wr_en, wr_last, rs_nxt, rd_last, chase_ok, mem_we, bank_free;
    logic [DW-1:0] mem [2**(AW+1)];
    logic [DW-1:0] rd_word;

    // Input side: a frame_start in any state restarts CP counting at this sample.
    always_comb begin
        in_nxt   = in_st;
        skip_nxt = skip_cnt;
        wa_nxt   = wr_addr;
        wr_ptr   = wr_addr;
        wr_en    = 1'b0;
        wr_last  = 1'b0;
        rs_nxt   = 1'b0;
        if (valid_in) begin
            if (frame_start) begin
                rs_nxt = (in_st != IN_IDLE);
                if (CP_LEN == 0) begin
                    in_nxt = IN_FILL;
                    wr_en  = 1'b1;
                    wr_ptr = '0;
                    wa_nxt = AW'(1);
                end else if (CP_LEN == 1) begin
                    in_nxt = IN_FILL;
                    wa_nxt = '0;
                end else begin
                    in_nxt   = IN_SKIP;
                    skip_nxt = AW'(1);
                end
            end else begin
                case (in_st)
                    IN_SKIP: begin
                        skip_nxt = skip_cnt + AW'(1);
                        if (skip_cnt == CP_LAST) begin
                            in_nxt = IN_FILL;
                            wa_nxt = '0;
                        end
                    end
                    IN_FILL: begin
                        wr_en  = 1'b1;
                        wa_nxt = wr_addr + AW'(1);
                        if (wr_addr == LAST_ADDR) begin
                            wr_last = 1'b1;
                            in_nxt  = IN_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Output side: fixed-length burst, flag_wayt_data only gates the start.
    always_comb begin
        out_nxt = out_st;
        ra_nxt  = rd_addr;
        rd_last = 1'b0;
        case (out_st)
            OUT_IDLE: if (full[rd_bank] && flag_wayt_data) begin
                out_nxt = OUT_RUN;
                ra_nxt  = '0;
            end
            OUT_RUN: begin
                ra_nxt = rd_addr + AW'(1);
                if (rd_addr == LAST_ADDR) begin
                    rd_last = 1'b1;
                    out_nxt = OUT_IDLE;
                end
            end
            default: ;
        endcase
    end

    // A full bank is only written behind the reader, so a frame that is still
    // queued is never corrupted; a bank freed on the completing cycle counts as free.
    assign chase_ok  = (out_st == OUT_RUN) && (rd_bank == wr_bank) && (wr_ptr <= rd_addr);
    assign mem_we    = wr_en && (!full[wr_bank] || chase_ok);
    assign bank_free = !full[wr_bank] || (rd_last && (rd_bank == wr_bank));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_st       <= IN_IDLE;
            out_st      <= OUT_IDLE;
            skip_cnt    <= '0;
            wr_addr     <= '0;
            rd_addr     <= '0;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            pend        <= 1'b0;
            pend_bank   <= 1'b0;
            full        <= '0;
            valid_out   <= 1'b0;
            overflow    <= 1'b0;
            resync      <= 1'b0;
            frame_count <= '0;
        end else begin
            in_st    <= in_nxt;
            skip_cnt <= skip_nxt;
            wr_addr  <= wa_nxt;
            resync   <= rs_nxt;
            overflow <= wr_last && !bank_free;
            pend     <= wr_last && bank_free;
            if (wr_last && bank_free) begin
                pend_bank <= wr_bank;
                wr_bank   <= ~wr_bank;
            end
            if (pend)
                full[pend_bank] <= 1'b1;
            if (rd_last) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
                frame_count   <= frame_count + CNT_W'(1);
            end
            out_st    <= out_nxt;
            rd_addr   <= ra_nxt;
            valid_out <= (out_st == OUT_RUN);
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[{wr_bank, wr_ptr}] <= {data_in_i, data_in_q};
        rd_word <= mem[{rd_bank, rd_addr}];
    end

    assign data_out_i = valid_out ? rd_word[DW-1 -: DATA_FFT_SIZE] : '0;
    assign data_out_q = valid_out ? rd_word[DATA_FFT_SIZE-1:0] : '0;
    assign busy       = (|full) || (out_st == OUT_RUN) || valid_out;

endmodule
